adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/ripple_carry_adder.sv | 31 +++
 rtl/adder_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared constants and FSM state type for the arbitrated adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    // Number of requesters sharing the adder and the width of their index.
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    // Arbiter/adder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : Parameterised ripple-carry adder, {cout_o, sum_o} = a + b + cin.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Carry chain: carry[k] is the carry into bit k.
    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    // One full adder per bit.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        assign sum_o[k]     = a_i[k] ^ b_i[k] ^ carry[k];
        assign carry[k + 1] = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k]));
    end

    assign cout_o = carry[WIDTH];

endmodule : ripple_carry_adder
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Four requesters share one adder through a round-robin
//                arbiter; one operation in flight, result held until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    input  logic [NREQ-1:0]               req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [adder_arb_pkg::ID_W-1:0] rsp_id,
    output logic [WIDTH-1:0]              rsp_sum,
    output logic                          rsp_cout,
    output logic                          busy
);

    import adder_arb_pkg::*;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                cin_q;
    logic [ID_W-1:0]     id_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [WIDTH-1:0]    rsp_sum_q;
    logic                rsp_cout_q;
    logic                busy_q;

    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_any;

    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;

    // Round-robin pick: first valid requester at or after ptr_q, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_q + ID_W'(i);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        grant[grant_id] = grant_any;
    end

    // Grant is only offered while idle; reset blanks it immediately.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

    // Shared adder, fed only from the capture registers.
    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Control FSM: capture on grant, register the sum, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        a_q     <= req_a[grant_id*WIDTH +: WIDTH];
                        b_q     <= req_b[grant_id*WIDTH +: WIDTH];
                        cin_q   <= req_cin[grant_id];
                        id_q    <= grant_id;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum_q   <= add_sum;
                    rsp_cout_q  <= add_cout;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ptr_q       <= id_q + ID_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = busy_q;

endmodule : adder_arbiter
`default_nettype wire
